// File: rtl/formula.sv
// Pipelined q = sat_N(((a-b)*(1+3c) - 4d) >>> 1), 5-cycle latency, one operand set per cycle, no backpressure.
// Optional FORMULA_HOLD_Q_EN: q holds the last valid result instead of being forced to 0 while o_valid is low.
module formula #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_valid,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  output logic                o_valid,
  output logic signed [N-1:0] q
);

  // W = 2N+4 is wide enough for every intermediate value at any input.
  localparam int W = 2 * N + 4;

  logic signed [W-1:0] w_a, w_b, w_c, w_d;
  logic signed [W-1:0] w_c3;
  logic signed [W-1:0] w_one;
  logic signed [W-1:0] w_max, w_min;
  logic signed [N-1:0] w_sat;

  logic signed [W-1:0] r_s, r_m, r_d4;
  logic signed [W-1:0] r_p, r_d4_2;
  logic signed [W-1:0] r_r;
  logic signed [W-1:0] r_h;
  logic signed [N-1:0] r_q;
  logic        [4:0]   r_vld;

  assign w_a   = {{(W-N){a[N-1]}}, a};
  assign w_b   = {{(W-N){b[N-1]}}, b};
  assign w_c   = {{(W-N){c[N-1]}}, c};
  assign w_d   = {{(W-N){d[N-1]}}, d};
  assign w_c3  = (w_c <<< 1) + w_c;
  assign w_one = {{(W-1){1'b0}}, 1'b1};

  // Saturation bounds, sign-extended to W bits for a signed compare.
  assign w_max = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  assign w_min = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  always_comb begin
    w_sat = r_h[N-1:0];
    if (r_h > w_max)
      w_sat = w_max[N-1:0];
    else if (r_h < w_min)
      w_sat = w_min[N-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s    <= '0;
      r_m    <= '0;
      r_d4   <= '0;
      r_p    <= '0;
      r_d4_2 <= '0;
      r_r    <= '0;
      r_h    <= '0;
      r_q    <= '0;
      r_vld  <= '0;
    end else begin
      r_vld  <= {r_vld[3:0], i_valid};
      r_s    <= w_a - w_b;
      r_m    <= w_c3 + w_one;
      r_d4   <= w_d <<< 2;
      r_p    <= r_s * r_m;
      r_d4_2 <= r_d4;
      r_r    <= r_p - r_d4_2;
      r_h    <= r_r >>> 1;
`ifdef FORMULA_HOLD_Q_EN
      if (r_vld[3])
        r_q <= w_sat;
`else
      r_q <= r_vld[3] ? w_sat : '0;
`endif
    end
  end

  assign o_valid = r_vld[4];
  assign q       = r_q;

endmodule

// File: tb/tb_formula.sv
// Directed bench for formula (N=8): arithmetic, saturation, floor rounding, latency, throughput, reset, idle q.
module tb_formula;

  logic              clk;
  logic              rstn;
  logic              i_valid;
  logic signed [7:0] a, b, c, d;
  logic              o_valid;
  logic signed [7:0] q;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [7:0] q_last;

  logic signed [7:0] sa [7];
  logic signed [7:0] sb [7];
  logic signed [7:0] sc [7];
  logic signed [7:0] sd [7];
  logic signed [7:0] se [7];

  formula #(.N(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .o_valid (o_valid),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [7:0] idle_q(input logic signed [7:0] last);
`ifdef FORMULA_HOLD_Q_EN
    return last;
`else
    return 8'sd0;
`endif
  endfunction

  // One isolated operand set: checks no early valid, the result 5 edges later, then the idle cycle.
  task automatic run_one(input string tag, input logic signed [7:0] va, input logic signed [7:0] vb,
                         input logic signed [7:0] vc, input logic signed [7:0] vd,
                         input logic signed [7:0] ex);
    @(negedge clk);
    i_valid = 1'b1; a = va; b = vb; c = vc; d = vd;
    @(negedge clk);
    i_valid = 1'b0; a = 8'sd0; b = 8'sd0; c = 8'sd0; d = 8'sd0;
    repeat (3) @(negedge clk);
    chk({tag, "_early_vld"}, o_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, o_valid, 1);
    chk({tag, "_q"}, q, ex);
    q_last = ex;
    @(negedge clk);
    chk({tag, "_idle_vld"}, o_valid, 0);
    chk({tag, "_idle_q"}, q, idle_q(q_last));
  endtask

  initial begin
    rstn = 1'b0; i_valid = 1'b0; a = 8'sd0; b = 8'sd0; c = 8'sd0; d = 8'sd0;
    q_last = 8'sd0;

    sa[0] = 1;    sb[0] = 2;    sc[0] = 3;    sd[0] = 4;    se[0] = -13;
    sa[1] = 10;   sb[1] = 20;   sc[1] = 5;    sd[1] = 10;   se[1] = -100;
    sa[2] = -5;   sb[2] = 10;   sc[2] = -20;  sd[2] = -1;   se[2] = 127;
    sa[3] = 120;  sb[3] = -25;  sc[3] = 7;    sd[3] = 6;    se[3] = 127;
    sa[4] = 127;  sb[4] = -128; sc[4] = 127;  sd[4] = -128; se[4] = 127;
    sa[5] = -120; sb[5] = 25;   sc[5] = 7;    sd[5] = 6;    se[5] = -128;
    sa[6] = 0;    sb[6] = 1;    sc[6] = 0;    sd[6] = 0;    se[6] = -1;

    #1;
    chk("reset_vld", o_valid, 0);
    chk("reset_q", q, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_one("basic_1234", 1, 2, 3, 4, -13);
    run_one("basic_neg100", 10, 20, 5, 10, -100);
    run_one("basic_zero", 0, 0, 0, 0, 0);
    run_one("pos_sat_444", -5, 10, -20, -1, 127);
    run_one("pos_sat_big", 120, -25, 7, 6, 127);
    run_one("pos_sat_ext", 127, -128, 127, -128, 127);
    run_one("neg_sat", -120, 25, 7, 6, -128);
    run_one("floor_m1", 0, 1, 0, 0, -1);

    // Back-to-back stream: driven at iteration i, expected at iteration i+5.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i >= 5 && i < 12) begin
        chk($sformatf("stream_vld_%0d", i), o_valid, 1);
        chk($sformatf("stream_q_%0d", i - 5), q, se[i-5]);
        q_last = se[i-5];
      end else begin
        chk($sformatf("stream_idle_vld_%0d", i), o_valid, 0);
        chk($sformatf("stream_idle_q_%0d", i), q, idle_q(q_last));
      end
      if (i < 7) begin
        i_valid = 1'b1; a = sa[i]; b = sb[i]; c = sc[i]; d = sd[i];
      end else begin
        i_valid = 1'b0; a = 8'sd0; b = 8'sd0; c = 8'sd0; d = 8'sd0;
      end
    end

    // Reset between edges while results are in flight and one is on the output.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("pre_reset_vld", o_valid, 1);
      i_valid = 1'b1; a = sa[i]; b = sb[i]; c = sc[i]; d = sd[i];
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_vld", o_valid, 0);
    chk("async_reset_q", q, 0);
    i_valid = 1'b0; a = 8'sd0; b = 8'sd0; c = 8'sd0; d = 8'sd0;
    repeat (2) @(negedge clk);
    chk("in_reset_q", q, 0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_vld_%0d", i), o_valid, 0);
    end

    run_one("after_reset", 1, 2, 3, 4, -13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
